// File: rtl/vga_params.sv
// Shared 640x480@60 raster constants and the RGB332 pixel layout.
// The renderer imports the same colour field definitions.
package vga_params;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int CNT_W = 10;

  localparam int RED_W     = 3;
  localparam int GREEN_W   = 3;
  localparam int BLUE_W    = 2;
  localparam int RED_LSB   = 5;
  localparam int GREEN_LSB = 2;
  localparam int BLUE_LSB  = 0;

  typedef struct packed {
    logic [RED_W-1:0]   red;
    logic [GREEN_W-1:0] green;
    logic [BLUE_W-1:0]  blue;
  } rgb332_t;

  // True while count lies in [start, start+width-1]; 11-bit sum avoids wrap at 1024.
  function automatic logic in_window(input logic [CNT_W-1:0] count,
                                     input logic [CNT_W-1:0] start,
                                     input logic [CNT_W-1:0] width);
    return ({1'b0, count} >= {1'b0, start}) &&
           ({1'b0, count} < ({1'b0, start} + {1'b0, width}));
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Pixel-side and pin-side signals of the VGA timing block.
// master = timing generator, slave = renderer / board pins.
interface vga_timing_if;
  import vga_params::*;

  logic [7:0]         color_in;
  logic               pix_ce;
  logic [CNT_W-1:0]   hcount;
  logic [CNT_W-1:0]   vcount;
  logic               active;
  logic               frame_start;
  logic [RED_W-1:0]   vgaRed;
  logic [GREEN_W-1:0] vgaGreen;
  logic [BLUE_W-1:0]  vgaBlue;
  logic               Hsync;
  logic               Vsync;

  modport master (
    input  color_in,
    output pix_ce, hcount, vcount, active, frame_start,
    output vgaRed, vgaGreen, vgaBlue, Hsync, Vsync
  );

  modport slave (
    output color_in,
    input  pix_ce, hcount, vcount, active, frame_start,
    input  vgaRed, vgaGreen, vgaBlue, Hsync, Vsync
  );
endinterface

// File: rtl/pixel_ce_gen.sv
// System-clock divider that emits a one-clock pixel strobe every CLK_DIV clocks.
// With CLK_DIV=1 the terminal count is 0, so the strobe is constantly high.
module pixel_ce_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_pix_ce
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;

  // Divider counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign o_pix_ce = (r_div == DIV_LAST);

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel counters, sync decode and the pin output register.
// Colour and sync are registered on the same strobe so they stay aligned at the connector.
module vga_timing
  import vga_params::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_WIDTH = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_WIDTH = CNT_W'(V_SYNC);

  logic             w_pix_ce;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic             r_active;
  rgb332_t          r_rgb;
  logic             r_hsync;
  logic             r_vsync;

  pixel_ce_gen #(.CLK_DIV(CLK_DIV)) u_ce (
    .clk      (clk),
    .rst_n    (rst_n),
    .o_pix_ce (w_pix_ce)
  );

  // Next raster position; feeds both the counters and the registered active flag.
  always_comb begin
    w_h_next = r_hcount;
    w_v_next = r_vcount;
    if (r_hcount == H_LAST) begin
      w_h_next = '0;
      if (r_vcount == V_LAST) begin
        w_v_next = '0;
      end else begin
        w_v_next = r_vcount + CNT_W'(1);
      end
    end else begin
      w_h_next = r_hcount + CNT_W'(1);
    end
  end

  // Raster counters and active flag, advancing once per pixel period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_active <= 1'b1;
    end else if (w_pix_ce) begin
      r_hcount <= w_h_next;
      r_vcount <= w_v_next;
      r_active <= (w_h_next < H_ACT) && (w_v_next < V_ACT);
    end
  end

  // Pin register: colour (blanked outside the visible area) and active-low syncs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_pix_ce) begin
      r_rgb   <= r_active ? rgb332_t'(bus.color_in) : rgb332_t'(8'h00);
      r_hsync <= ~in_window(r_hcount, HS_START, HS_WIDTH);
      r_vsync <= ~in_window(r_vcount, VS_START, VS_WIDTH);
    end
  end

  assign bus.pix_ce      = w_pix_ce;
  assign bus.hcount      = r_hcount;
  assign bus.vcount      = r_vcount;
  assign bus.active      = r_active;
  assign bus.frame_start = w_pix_ce && (r_hcount == '0) && (r_vcount == '0);
  assign bus.vgaRed      = r_rgb.red;
  assign bus.vgaGreen    = r_rgb.green;
  assign bus.vgaBlue     = r_rgb.blue;
  assign bus.Hsync       = r_hsync;
  assign bus.Vsync       = r_vsync;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full-size instance for horizontal timing and mid-line reset,
// shrunken rasters for whole-frame checks and the CLK_DIV=1 corner.
module tb_vga_timing;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic mode  = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vga_timing_if bus_def ();
  vga_timing_if bus_sml ();
  vga_timing_if bus_c1 ();

  assign bus_def.color_in = 8'hFF;
  assign bus_c1.color_in  = 8'h00;
  assign bus_sml.color_in = mode ? {bus_sml.hcount[4:0], bus_sml.vcount[2:0]} : 8'hFF;

  vga_timing u_def (.clk(clk), .rst_n(rst_n), .bus(bus_def));

  vga_timing #(.CLK_DIV(4), .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
               .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3))
    u_sml (.clk(clk), .rst_n(rst_n), .bus(bus_sml));

  vga_timing #(.CLK_DIV(1), .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
               .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3))
    u_c1 (.clk(clk), .rst_n(rst_n), .bus(bus_c1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for 10 clocks, release just after a falling edge: next rising edge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (bus_def.hcount !== 10'd0) begin bad++; $display("FAIL reset_hcount: got %0d want 0", bus_def.hcount); end
    total++; if (bus_def.vcount !== 10'd0) begin bad++; $display("FAIL reset_vcount: got %0d want 0", bus_def.vcount); end
    total++; if (bus_def.active !== 1'b1) begin bad++; $display("FAIL reset_active: got %b want 1", bus_def.active); end
    total++; if ({bus_def.vgaRed, bus_def.vgaGreen, bus_def.vgaBlue} !== 8'h00) begin bad++; $display("FAIL reset_colour: got %h want 00", {bus_def.vgaRed, bus_def.vgaGreen, bus_def.vgaBlue}); end
    total++; if ({bus_def.Hsync, bus_def.Vsync} !== 2'b11) begin bad++; $display("FAIL reset_sync: got %b want 11", {bus_def.Hsync, bus_def.Vsync}); end
    total++; if (bus_def.pix_ce !== 1'b0) begin bad++; $display("FAIL reset_pix_ce: got %b want 0", bus_def.pix_ce); end
    total++; if (bus_def.frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start: got %b want 0", bus_def.frame_start); end
    total++; if (bus_c1.pix_ce !== 1'b1) begin bad++; $display("FAIL reset_c1_pix_ce: got %b want 1", bus_c1.pix_ce); end
    total++; if (bus_c1.frame_start !== 1'b1) begin bad++; $display("FAIL reset_c1_frame_start: got %b want 1", bus_c1.frame_start); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs straight after test_reset's release.
  task automatic test_strobe();
    for (int k = 1; k <= 20; k++) begin
      step();
      total++; if (bus_def.pix_ce !== ((k % 4) == 3)) begin bad++; $display("FAIL strobe_pix_ce k=%0d: got %b want %b", k, bus_def.pix_ce, ((k % 4) == 3)); end
      total++; if (bus_def.frame_start !== (k == 3)) begin bad++; $display("FAIL strobe_frame_start k=%0d: got %b want %b", k, bus_def.frame_start, (k == 3)); end
      total++; if (bus_def.hcount !== 10'(k / 4)) begin bad++; $display("FAIL strobe_hcount k=%0d: got %0d want %0d", k, bus_def.hcount, k / 4); end
      total++; if (bus_c1.hcount !== 10'(k)) begin bad++; $display("FAIL strobe_c1_hcount k=%0d: got %0d want %0d", k, bus_c1.hcount, k); end
      total++; if (bus_c1.pix_ce !== 1'b1) begin bad++; $display("FAIL strobe_c1_pix_ce k=%0d: got %b want 1", k, bus_c1.pix_ce); end
    end
  endtask

  task automatic test_horizontal();
    int   t656 = 0;
    int   tv1  = 0;
    int   tf1  = 0;
    int   tr1  = 0;
    int   tf2  = 0;
    logic prev_hs = 1'b1;
    logic act639  = 1'b0;
    logic act640  = 1'b1;
    logic vs_low  = 1'b0;
    do_reset();
    for (int k = 1; k <= 7000; k++) begin
      step();
      if (t656 == 0 && bus_def.hcount == 10'd656) t656 = k;
      if (tv1 == 0 && bus_def.vcount == 10'd1) tv1 = k;
      if (bus_def.hcount == 10'd639 && bus_def.vcount == 10'd0) act639 = bus_def.active;
      if (bus_def.hcount == 10'd640 && bus_def.vcount == 10'd0) act640 = bus_def.active;
      if (!bus_def.Vsync) vs_low = 1'b1;
      if (prev_hs && !bus_def.Hsync) begin
        if (tf1 == 0) tf1 = k; else if (tf2 == 0) tf2 = k;
      end
      if (!prev_hs && bus_def.Hsync && tr1 == 0) tr1 = k;
      prev_hs = bus_def.Hsync;
    end
    total++; if (t656 != 2624) begin bad++; $display("FAIL h_reach_656: got %0d want 2624", t656); end
    total++; if (tf1 - t656 != 4) begin bad++; $display("FAIL h_fall_latency: got %0d want 4", tf1 - t656); end
    total++; if (tr1 - tf1 != 384) begin bad++; $display("FAIL h_sync_width: got %0d want 384", tr1 - tf1); end
    total++; if (tf2 - tf1 != 3200) begin bad++; $display("FAIL h_sync_period: got %0d want 3200", tf2 - tf1); end
    total++; if (tv1 != 3200) begin bad++; $display("FAIL h_line_wrap: got %0d want 3200", tv1); end
    total++; if (act639 !== 1'b1) begin bad++; $display("FAIL h_active_639: got %b want 1", act639); end
    total++; if (act640 !== 1'b0) begin bad++; $display("FAIL h_active_640: got %b want 0", act640); end
    total++; if (vs_low !== 1'b0) begin bad++; $display("FAIL h_vsync_quiet: got %b want 0", vs_low); end
  endtask

  // Small raster: H_TOTAL=32, V_TOTAL=15, 1920 clks per frame.
  task automatic test_vertical();
    int   fs_cnt = 0;
    int   fs1 = 0;
    int   fs2 = 0;
    int   vf1 = 0;
    int   vr1 = 0;
    int   vf2 = 0;
    int   hf1 = 0;
    int   hr1 = 0;
    logic prev_vs = 1'b1;
    logic prev_hs = 1'b1;
    do_reset();
    for (int k = 1; k <= 4000; k++) begin
      step();
      if (bus_sml.frame_start) begin
        fs_cnt++;
        if (fs1 == 0) fs1 = k; else if (fs2 == 0) fs2 = k;
      end
      if (prev_vs && !bus_sml.Vsync) begin
        if (vf1 == 0) vf1 = k; else if (vf2 == 0) vf2 = k;
      end
      if (!prev_vs && bus_sml.Vsync && vr1 == 0) vr1 = k;
      if (prev_hs && !bus_sml.Hsync && hf1 == 0) hf1 = k;
      if (!prev_hs && bus_sml.Hsync && hr1 == 0) hr1 = k;
      prev_vs = bus_sml.Vsync;
      prev_hs = bus_sml.Hsync;
    end
    total++; if (fs_cnt != 3) begin bad++; $display("FAIL v_frame_count: got %0d want 3", fs_cnt); end
    total++; if (fs1 != 3) begin bad++; $display("FAIL v_first_frame_start: got %0d want 3", fs1); end
    total++; if (fs2 - fs1 != 1920) begin bad++; $display("FAIL v_frame_period: got %0d want 1920", fs2 - fs1); end
    total++; if (vf1 != 1284) begin bad++; $display("FAIL v_sync_fall: got %0d want 1284", vf1); end
    total++; if (vr1 - vf1 != 256) begin bad++; $display("FAIL v_sync_width: got %0d want 256", vr1 - vf1); end
    total++; if (vf2 - vf1 != 1920) begin bad++; $display("FAIL v_sync_period: got %0d want 1920", vf2 - vf1); end
    total++; if (hf1 != 84) begin bad++; $display("FAIL v_small_hsync_fall: got %0d want 84", hf1); end
    total++; if (hr1 - hf1 != 32) begin bad++; $display("FAIL v_small_hsync_width: got %0d want 32", hr1 - hf1); end
  endtask

  // Pixel m is registered on edge 4*(m+1); colour model per pixel over one frame.
  task automatic test_frame_colour(input logic pat);
    int         errs = 0;
    int         first_k = 0;
    int         nz_cnt = 0;
    int         first_nz = 0;
    int         m;
    int         h;
    int         v;
    logic [7:0] exp_c;
    logic [7:0] got_c;
    logic [7:0] bad_got = 8'h00;
    logic [7:0] bad_exp = 8'h00;
    mode = pat;
    do_reset();
    for (int k = 1; k <= 1923; k++) begin
      step();
      exp_c = 8'h00;
      if (k >= 4) begin
        m = k / 4 - 1;
        h = m % 32;
        v = (m / 32) % 15;
        if (h < 16 && v < 8) exp_c = pat ? {5'(h), 3'(v)} : 8'hFF;
      end
      got_c = {bus_sml.vgaRed, bus_sml.vgaGreen, bus_sml.vgaBlue};
      if (got_c !== 8'h00) begin
        nz_cnt++;
        if (first_nz == 0) first_nz = k;
      end
      if (got_c !== exp_c) begin
        errs++;
        if (first_k == 0) begin first_k = k; bad_got = got_c; bad_exp = exp_c; end
      end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL colour_model mode=%b: %0d bad clks, first k=%0d got %h want %h", pat, errs, first_k, bad_got, bad_exp); end
    if (!pat) begin
      total++; if (first_nz != 4) begin bad++; $display("FAIL blank_first_colour: got %0d want 4", first_nz); end
      total++; if (nz_cnt != 512) begin bad++; $display("FAIL blank_visible_clks: got %0d want 512", nz_cnt); end
    end
    mode = 1'b0;
  endtask

  task automatic test_async_reset();
    int found = 0;
    do_reset();
    for (int k = 1; k <= 2000 && found == 0; k++) begin
      step();
      if (bus_def.hcount == 10'd300) found = k;
    end
    total++; if (found != 1200) begin bad++; $display("FAIL areset_reach_300: got %0d want 1200", found); end
    total++; if ({bus_def.vgaRed, bus_def.vgaGreen, bus_def.vgaBlue} !== 8'hFF) begin bad++; $display("FAIL areset_pre_colour: got %h want ff", {bus_def.vgaRed, bus_def.vgaGreen, bus_def.vgaBlue}); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus_def.hcount !== 10'd0 || bus_def.vcount !== 10'd0) begin bad++; $display("FAIL areset_counters: got %0d,%0d want 0,0", bus_def.hcount, bus_def.vcount); end
    total++; if (bus_def.active !== 1'b1) begin bad++; $display("FAIL areset_active: got %b want 1", bus_def.active); end
    total++; if ({bus_def.vgaRed, bus_def.vgaGreen, bus_def.vgaBlue} !== 8'h00) begin bad++; $display("FAIL areset_colour: got %h want 00", {bus_def.vgaRed, bus_def.vgaGreen, bus_def.vgaBlue}); end
    total++; if (bus_def.pix_ce !== 1'b0) begin bad++; $display("FAIL areset_pix_ce: got %b want 0", bus_def.pix_ce); end
    total++; if ({bus_def.Hsync, bus_def.Vsync} !== 2'b11) begin bad++; $display("FAIL areset_sync: got %b want 11", {bus_def.Hsync, bus_def.Vsync}); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      total++; if (bus_def.pix_ce !== ((k % 4) == 3)) begin bad++; $display("FAIL areset_resume_pix_ce k=%0d: got %b want %b", k, bus_def.pix_ce, ((k % 4) == 3)); end
      total++; if (bus_def.hcount !== 10'(k / 4) || bus_def.vcount !== 10'd0) begin bad++; $display("FAIL areset_resume_pos k=%0d: got %0d,%0d want %0d,0", k, bus_def.hcount, bus_def.vcount, k / 4); end
    end
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_horizontal();
    test_vertical();
    test_frame_colour(1'b0);
    test_frame_colour(1'b1);
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates 640x480@60 Hz VGA raster timing from the 100 MHz `clk` and drives the board VGA pins. Sits directly upstream of the Breakout pixel renderer: it publishes the current pixel coordinate, and the renderer returns an RGB332 colour for that coordinate. It registers that colour together with `Hsync`/`Vsync` so colour and sync reach the connector aligned. It forces black outside the active area.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel; valid range ≥1.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk`, in, 1: system clock, 100 MHz.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `color_in`, in, 8: RGB332 colour from the renderer for the current `hcount`/`vcount`; [7:5] red, [4:2] green, [1:0] blue.
- `pix_ce`, out, 1: pixel strobe; high for 1 clk per pixel period.
- `hcount`, out, 10: current pixel column, 0..H_TOTAL-1.
- `vcount`, out, 10: current line, 0..V_TOTAL-1.
- `active`, out, 1: high when `hcount`<H_ACTIVE and `vcount`<V_ACTIVE.
- `frame_start`, out, 1: 1-clk pulse at pixel (0,0).
- `vgaRed`, out, 3: registered red output.
- `vgaGreen`, out, 3: registered green output.
- `vgaBlue`, out, 2: registered blue output.
- `Hsync`, out, 1: registered horizontal sync, active-low.
- `Vsync`, out, 1: registered vertical sync, active-low.

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. Both must be ≤1024 (10-bit counters).
- Divider: 2-bit counter `div` runs 0..CLK_DIV-1.
  - `pix_ce` = (`div`==CLK_DIV-1).
  - When CLK_DIV=1, `pix_ce` is constantly 1 out of reset.
- Counters advance only on edges where `pix_ce`=1:
  - `hcount` wraps H_TOTAL-1 → 0.
  - `vcount` increments on an `hcount` wrap and wraps V_TOTAL-1 → 0.
- Sync, with default parameters:
  - hsync is asserted for `hcount` in [656, 751].
  - vsync is asserted for `vcount` in [490, 491].
  - Both are asserted low.
- Output stage: on each `pix_ce` edge it registers the following for the current `hcount`/`vcount`:
  - `{vgaRed,vgaGreen,vgaBlue}` = `active` ? `color_in` : 0.
  - The hsync and vsync levels.
- `frame_start` = `pix_ce` && `hcount`==0 && `vcount`==0. It fires exactly once per frame.
- Reset values, applied immediately on `rst_n`=0 with no clock edge:
  - `div`=0, `hcount`=0, `vcount`=0.
  - `pix_ce`=0 (1 if CLK_DIV=1), `frame_start`=0 (1 if CLK_DIV=1). `active`=1, which follows from counters at (0,0).
  - colour outputs 0, `Hsync`=1, `Vsync`=1.
- Reset mid-frame: all state clears asynchronously. After release, the raster restarts at (0,0), and the first `pix_ce` occurs on the CLK_DIV-th clock after release.

## Timing
- One pixel period is CLK_DIV clks; `hcount`/`vcount` hold for the whole period.
- Renderer budget: `color_in` must be valid by the clk in which `pix_ce`=1. That is ≤CLK_DIV-1 clks after the counters change, i.e. up to a 3-stage renderer pipeline.
- Latency: colour and sync for pixel (h,v) appear on the pins one pixel period (4 clks) after the counters present (h,v). Colour and sync share this latency, so they are always mutually aligned.
- Line length: 3200 clks. Frame length: 1,680,000 clks (16.8 ms).
- `active`, `hcount` and `vcount` are registered; `pix_ce` and `frame_start` are decoded from registers with no combinational path from inputs.

## Structure
- Shared package `vga_params` holds:
  - the 640x480@60 timing constants;
  - H_TOTAL/V_TOTAL;
  - RGB332 field widths and positions, which the renderer also uses.
- One sub-module, `pixel_ce_gen`: the divider producing `pix_ce`, parameterised by CLK_DIV.
- Counter, sync decode and output register logic live in `vga_timing`.

## Test plan
- Reset: hold `rst_n`=0 for 10 clks → counters 0, `active`=1, colour outputs 0, `Hsync`=`Vsync`=1, `pix_ce`=0.
- Strobe: release reset → `pix_ce` high on clks 4, 8, 12, … only; `frame_start` is one pulse coincident with the first `pix_ce`.
- Horizontal: measure `Hsync` → low for 384 clks, repeating every 3200 clks. The falling edge occurs 4 clks after `hcount` becomes 656.
- Vertical: run 2 frames → `Vsync` low for 6400 clks, period 1,680,000 clks; exactly one `frame_start` per frame.
- Blanking: `color_in`=8'hFF → `vgaRed`=7, `vgaGreen`=7, `vgaBlue`=3 for 640 pixels per line on lines 0..479, and 0 elsewhere. The first nonzero colour appears 4 clks after (0,0).
- Async reset mid-line at `hcount`=300 → outputs take reset values before the next clk edge; after release, counting resumes from (0,0).
